// File: rtl/serial_magnitude_comparator_pkg.sv
// Shared types for the digit-serial magnitude comparator: FSM states and result flags.
package serial_comp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic less;
    logic greater;
    logic equal;
  } result_t;

endpackage

// File: rtl/serial_magnitude_comparator_digit_comparator.sv
// Combinational DIGIT-bit slice compare, cascaded MSB to LSB from the running flags.
module digit_comparator #(
  parameter int unsigned DIGIT = 2
) (
  input  logic [DIGIT-1:0] a_slice,
  input  logic [DIGIT-1:0] b_slice,
  input  logic             prev_less,
  input  logic             prev_greater,
  input  logic             prev_equal,
  output logic             cur_less_c,
  output logic             cur_greater_c,
  output logic             cur_equal_c
);

  always_comb begin
    cur_less_c    = prev_less;
    cur_greater_c = prev_greater;
    cur_equal_c   = prev_equal;
    // Once any higher bit differs, equal drops and freezes the decision.
    for (int i = DIGIT - 1; i >= 0; i--) begin
      cur_less_c    = cur_less_c    | (cur_equal_c & ~a_slice[i] &  b_slice[i]);
      cur_greater_c = cur_greater_c | (cur_equal_c &  a_slice[i] & ~b_slice[i]);
      cur_equal_c   = cur_equal_c   & ~(a_slice[i] ^ b_slice[i]);
    end
  end

endmodule

// File: rtl/serial_magnitude_comparator.sv
// Digit-serial unsigned/two's-complement magnitude comparator with valid/ready handshakes.
// Define SERIAL_COMP_EARLY_EXIT_EN to finish as soon as the first differing digit is seen.
module serial_magnitude_comparator
  import serial_comp_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             less,
  output logic             greater,
  output logic             equal,
  output logic             busy
);

  localparam int unsigned N     = WIDTH / DIGIT;
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
`ifdef SERIAL_COMP_EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  result_t            run_q;
  result_t            cur_c;
  logic [WIDTH-1:0]   a_cap_c;
  logic [WIDTH-1:0]   b_cap_c;
  logic               last_c;

  // Signed compare becomes unsigned once the sign bits are flipped.
  always_comb begin
    a_cap_c            = a;
    b_cap_c            = b;
    a_cap_c[WIDTH-1]   = a[WIDTH-1] ^ signed_mode;
    b_cap_c[WIDTH-1]   = b[WIDTH-1] ^ signed_mode;
  end

  digit_comparator #(
    .DIGIT(DIGIT)
  ) u_digit (
    .a_slice      (a_q[WIDTH-1 -: DIGIT]),
    .b_slice      (b_q[WIDTH-1 -: DIGIT]),
    .prev_less    (run_q.less),
    .prev_greater (run_q.greater),
    .prev_equal   (run_q.equal),
    .cur_less_c   (cur_c.less),
    .cur_greater_c(cur_c.greater),
    .cur_equal_c  (cur_c.equal)
  );

  assign last_c = (idx == '0) || (EARLY_EXIT && (cur_c.less || cur_c.greater));

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      run_q     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      less      <= 1'b0;
      greater   <= 1'b0;
      equal     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            state    <= RUN;
            idx      <= IDX_W'(N - 1);
            a_q      <= a_cap_c;
            b_q      <= b_cap_c;
            run_q    <= '{less: 1'b0, greater: 1'b0, equal: 1'b1};
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          run_q <= cur_c;
          a_q   <= a_q << DIGIT;
          b_q   <= b_q << DIGIT;
          if (last_c) begin
            state     <= DONE;
            out_valid <= 1'b1;
            less      <= cur_c.less;
            greater   <= cur_c.greater;
            equal     <= ~cur_c.less & ~cur_c.greater;
          end else begin
            idx <= idx - IDX_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            less      <= 1'b0;
            greater   <= 1'b0;
            equal     <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Scoreboard bench for serial_magnitude_comparator: DIGIT=2 (N=4) and DIGIT=8 (N=1) instances.
module tb_serial_magnitude_comparator;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       out_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       signed_mode;
  logic       sel;

  logic in_ready0, out_valid0, less0, greater0, equal0, busy0;
  logic in_ready1, out_valid1, less1, greater1, equal1, busy1;

  logic       m_in_ready, m_out_valid, m_busy;
  logic [2:0] m_flags;

  typedef struct {
    logic [2:0] flags;
    int         lat;
    string      tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  serial_magnitude_comparator #(.WIDTH(8), .DIGIT(2)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid & ~sel), .in_ready(in_ready0),
    .a(a), .b(b), .signed_mode(signed_mode),
    .out_valid(out_valid0), .out_ready(out_ready & ~sel),
    .less(less0), .greater(greater0), .equal(equal0), .busy(busy0)
  );

  serial_magnitude_comparator #(.WIDTH(8), .DIGIT(8)) dut_n1 (
    .clk(clk), .reset(reset), .in_valid(in_valid & sel), .in_ready(in_ready1),
    .a(a), .b(b), .signed_mode(signed_mode),
    .out_valid(out_valid1), .out_ready(out_ready & sel),
    .less(less1), .greater(greater1), .equal(equal1), .busy(busy1)
  );

  assign m_in_ready  = sel ? in_ready1  : in_ready0;
  assign m_out_valid = sel ? out_valid1 : out_valid0;
  assign m_busy      = sel ? busy1      : busy0;
  assign m_flags     = sel ? {less1, greater1, equal1} : {less0, greater0, equal0};

  task automatic check(input string tag, input int got, input int expv);
    n_vec++;
    if (got !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t model(input logic [7:0] oa, input logic [7:0] ob,
                                 input bit sm, input int digit, input string tag);
    exp_t e;
    int va, vb, n;
    logic [7:0] ca, cb;
    va = int'(oa);
    vb = int'(ob);
    if (sm && oa[7]) va = va - 256;
    if (sm && ob[7]) vb = vb - 256;
    e.flags = (va < vb) ? 3'b100 : (va > vb) ? 3'b010 : 3'b001;
    n = 8 / digit;
    e.lat = n;
`ifdef SERIAL_COMP_EARLY_EXIT_EN
    ca = oa ^ {sm, 7'b0};
    cb = ob ^ {sm, 7'b0};
    for (int d = n - 1; d >= 0; d--) begin
      if (((ca >> (d * digit)) & 8'((1 << digit) - 1)) != ((cb >> (d * digit)) & 8'((1 << digit) - 1))) begin
        e.lat = n - d;
        break;
      end
    end
`else
    ca = 8'h00;
    cb = 8'h00;
    if (ca != cb) e.lat = 0;
`endif
    e.tag = tag;
    return e;
  endfunction

  task automatic check_idle(input string tag);
    check({tag, ".in_ready"}, int'(m_in_ready), 1);
    check({tag, ".out_valid"}, int'(m_out_valid), 0);
    check({tag, ".busy"}, int'(m_busy), 0);
    check({tag, ".flags"}, int'(m_flags), 0);
  endtask

  // Accept one operation, push its expectation, wait for the result, hold, then release.
  task automatic run_op(input bit s, input logic [7:0] oa, input logic [7:0] ob,
                        input bit sm, input int hold, input string tag);
    exp_t e;
    int   lat;
    int   guard;
    sel   = s;
    guard = 0;
    while (!m_in_ready && guard < 20) begin
      tick();
      guard++;
    end
    check({tag, ".ready_wait"}, int'(m_in_ready), 1);
    a           = oa;
    b           = ob;
    signed_mode = sm;
    in_valid    = 1'b1;
    exp_q.push_back(model(oa, ob, sm, s ? 8 : 2, tag));
    tick();
    lat = 0;
    while (!m_out_valid && lat < 40) begin
      a           = 8'($urandom);
      b           = 8'($urandom);
      signed_mode = 1'($urandom);
      tick();
      lat++;
    end
    e = exp_q.pop_front();
    check({e.tag, ".latency"}, lat, e.lat);
    check({e.tag, ".flags"}, int'(m_flags), int'(e.flags));
    check({e.tag, ".busy"}, int'(m_busy), 1);
    for (int i = 0; i < hold; i++) begin
      tick();
      check({e.tag, ".hold_valid"}, int'(m_out_valid), 1);
      check({e.tag, ".hold_flags"}, int'(m_flags), int'(e.flags));
      check({e.tag, ".hold_in_ready"}, int'(m_in_ready), 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_idle({e.tag, ".release"});
  endtask

  initial begin
    reset       = 1'b1;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    a           = 8'h00;
    b           = 8'h00;
    signed_mode = 1'b0;
    sel         = 1'b0;
    tick();
    tick();
    check_idle("reset");
    sel = 1'b1;
    check_idle("reset_n1");
    sel   = 1'b0;
    reset = 1'b0;
    tick();

    run_op(1'b0, 8'hA5, 8'hA5, 1'b0, 0, "eq_a5");
    run_op(1'b0, 8'h80, 8'h7F, 1'b0, 0, "u80_7f");
    run_op(1'b0, 8'h80, 8'h7F, 1'b1, 0, "s80_7f");
    run_op(1'b0, 8'h40, 8'h00, 1'b0, 0, "early40");
    run_op(1'b0, 8'h12, 8'h13, 1'b0, 5, "hold5");

    // Reset lands in the second RUN cycle and must discard the operation.
    a        = 8'h10;
    b        = 8'h20;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_idle("mid_reset");
    run_op(1'b0, 8'h01, 8'h02, 1'b0, 0, "after_reset");

    run_op(1'b1, 8'd3, 8'd5, 1'b0, 0, "n1_3_5");
    run_op(1'b1, 8'hFF, 8'h01, 1'b1, 0, "n1_sneg");

    for (int i = 0; i < 16; i++) begin
      logic [7:0] ra, rb;
      ra = 8'($urandom);
      rb = (i % 4 == 0) ? ra : 8'($urandom);
      run_op(1'($urandom), ra, rb, 1'($urandom), i % 3, "rand");
    end

    check("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/serial_magnitude_comparator.md
SERIAL_MAGNITUDE_COMPARATOR -- requirements
Module: serial_magnitude_comparator

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand width in bits; minimum 1.
REQ-002 SHALL have parameter DIGIT, default 2: bits compared per cycle; WIDTH SHALL be an integer multiple of DIGIT; N = WIDTH/DIGIT.
REQ-003 SHALL have port clk, input, 1 bit: single clock, all state on rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have ports in_valid (input, 1), in_ready (output, 1): operand handshake.
REQ-006 SHALL have ports a and b (input, WIDTH): operands.
REQ-007 SHALL have port signed_mode (input, 1): 1 = two's-complement compare, 0 = unsigned; sampled with operands.
REQ-008 SHALL have ports out_valid (output, 1), out_ready (input, 1): result handshake.
REQ-009 SHALL have ports less, greater, equal (output, 1 each): result flags, a relative to b.
REQ-010 SHALL have port busy (output, 1): high in RUN or DONE.

Function
REQ-011 SHALL implement FSM states IDLE, RUN, DONE.
REQ-012 in_ready SHALL be 1 only in IDLE; a, b, signed_mode SHALL be captured on the edge where in_valid && in_ready.
REQ-013 In signed mode the operand MSBs SHALL be inverted at capture, then compared unsigned.
REQ-014 Accept edge SHALL move IDLE->RUN with digit index at N-1 and running flags less=0, greater=0, equal-pending=1.
REQ-015 Each RUN cycle SHALL compare one DIGIT-bit slice, MSB slice first, cascading from the running flags: less |= (eq & slice_a<slice_b); greater |= (eq & slice_a>slice_b).
REQ-016 RUN->DONE SHALL occur on the edge that processes digit 0; out_valid SHALL rise exactly N edges after the accept edge.
REQ-017 In DONE, out_valid SHALL be 1 and exactly one of less/greater/equal SHALL be 1; equal = ~less & ~greater.
REQ-018 less, greater, equal SHALL be 0 whenever out_valid is 0.
REQ-019 Outputs SHALL hold stable while out_valid && !out_ready.
REQ-020 out_valid && out_ready SHALL move DONE->IDLE; in_ready SHALL rise the following cycle (no same-cycle reaccept).
REQ-021 in_valid in RUN or DONE SHALL be ignored; changes to a/b after capture SHALL not affect the result.

Reset
REQ-022 reset SHALL force IDLE, in_ready=1, out_valid=0, busy=0, less=greater=equal=0, digit index 0, on the next edge, from any state including mid-RUN; an in-flight operation is discarded.
REQ-023 reset SHALL take priority over both handshakes in the same cycle.

Configuration
REQ-024 Macro SERIAL_COMP_EARLY_EXIT_EN: when defined, RUN->DONE SHALL also occur on the edge where less or greater first becomes 1; out_valid rises d edges after accept, d = 1-based position (from MSB) of first differing digit, or N if equal.
REQ-025 Without SERIAL_COMP_EARLY_EXIT_EN, latency SHALL always be N edges regardless of data.

Structure
REQ-026 Package serial_comp_pkg SHALL hold the FSM state enum and a result struct {less, greater, equal}.
REQ-027 Sub-module digit_comparator (combinational, DIGIT-bit, prev_less/prev_greater/prev_equal in, cur flags out, built as an MSB-to-LSB bit cascade) SHALL perform the per-cycle slice compare.

Verification (WIDTH=8, DIGIT=2, N=4 unless stated)
REQ-028 a=0xA5, b=0xA5, unsigned -> equal=1, out_valid 4 edges after accept (either config).
REQ-029 a=0x80, b=0x7F: unsigned -> greater=1; signed_mode=1 -> less=1.
REQ-030 a=0x40, b=0x00 -> greater=1 after 1 edge with SERIAL_COMP_EARLY_EXIT_EN, after 4 edges without.
REQ-031 Result ready, out_ready held 0 for 5 cycles -> out_valid, flags stable, in_ready=0; out_ready=1 -> IDLE, in_ready=1 next cycle.
REQ-032 reset asserted during 2nd RUN cycle -> next cycle in_ready=1, out_valid=0, flags 0; subsequent a=0x01, b=0x02 -> less=1.
REQ-033 WIDTH=8, DIGIT=8 (N=1): a=3, b=5 -> less=1, out_valid 1 edge after accept.
